// File: rtl/serial_nibble_rx.sv
// Oversampling receiver for the start/sclk/sdi serial link: assembles DATA_W-bit
// words and flags clean frame ends, partial frames and stalled bit clocks.
module serial_nibble_rx #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned STALL_LIMIT = 8,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sclk,
    input  logic              sdi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              err_frame,
    output logic              err_stall,
    output logic              busy
);

    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned STALL_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERROR  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic start_s1_q, start_s2_q, start_s3_q;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic sdi_s1_q, sdi_s2_q;

    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_after;
    logic [STALL_W-1:0] stall_q, stall_d, stall_nxt;
    logic [DATA_W-1:0]  shift_q, shift_d, shifted;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               busy_q, busy_d;

    // Event stage: decisions made on the edge-detect cycle, published one cycle later
    logic evt_valid_q, evt_valid_d;
    logic evt_done_q, evt_done_d;
    logic evt_ferr_q, evt_ferr_d;
    logic evt_stall_q, evt_stall_d;

    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q, frame_done_q, err_frame_q, err_stall_q;

    logic sclk_rise, sclk_edge, start_fall, word_done, stall_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            sclk_s1_q  <= sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
            sdi_s1_q   <= sdi;
            sdi_s2_q   <= sdi_s1_q;
        end
    end

    assign sclk_rise  = sclk_s2_q & ~sclk_s3_q;
    assign sclk_edge  = sclk_s2_q ^ sclk_s3_q;
    assign start_fall = ~start_s2_q & start_s3_q;

    assign shifted   = MSB_FIRST ? {shift_q[DATA_W-2:0], sdi_s2_q}
                                 : {sdi_s2_q, shift_q[DATA_W-1:1]};
    assign word_done = sclk_rise && (cnt_q + CNT_W'(1) == CNT_W'(DATA_W));
    assign cnt_after = !sclk_rise ? cnt_q : (word_done ? '0 : cnt_q + CNT_W'(1));
    assign stall_nxt = sclk_edge ? '0
                     : ((stall_q == {STALL_W{1'b1}}) ? stall_q : stall_q + STALL_W'(1));
    assign stall_hit = stall_nxt >= STALL_W'(STALL_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_q     <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_done_q  <= 1'b0;
            evt_ferr_q  <= 1'b0;
            evt_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            evt_valid_q <= evt_valid_d;
            evt_done_q  <= evt_done_d;
            evt_ferr_q  <= evt_ferr_d;
            evt_stall_q <= evt_stall_d;
        end
    end

    // Next-state logic; start_fall takes priority over a same-cycle stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_s2_q) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (start_fall)     state_d = S_IDLE;
                else if (stall_hit) state_d = S_ERROR;
            end
            S_ERROR:  if (!start_s2_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and strobe decisions
    always_comb begin
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        shift_d     = shift_q;
        word_d      = word_q;
        evt_valid_d = 1'b0;
        evt_done_d  = 1'b0;
        evt_ferr_d  = 1'b0;
        evt_stall_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_s2_q) begin
                    cnt_d   = '0;
                    stall_d = '0;
                    shift_d = '0;
                end
            end
            S_ACTIVE: begin
                stall_d = stall_nxt;
                if (sclk_rise) begin
                    shift_d     = shifted;
                    cnt_d       = cnt_after;
                    evt_valid_d = word_done;
                    if (word_done) word_d = shifted;
                end
                if (start_fall) begin
                    if (cnt_after == '0) begin
                        evt_done_d = 1'b1;
                    end else begin
                        evt_ferr_d = 1'b1;
                        cnt_d      = '0;
                        shift_d    = '0;
                    end
                end else if (stall_hit) begin
                    evt_stall_d = 1'b1;
                    cnt_d       = '0;
                    shift_d     = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_frame_q  <= 1'b0;
            err_stall_q  <= 1'b0;
        end else begin
            if (evt_valid_q) dout_q <= word_q;
            dout_valid_q <= evt_valid_q;
            frame_done_q <= evt_done_q;
            err_frame_q  <= evt_ferr_q;
            err_stall_q  <= evt_stall_q;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign err_frame  = err_frame_q;
    assign err_stall  = err_stall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx: directed scenarios plus randomized
// frames compared against a bit-list model of the link.
module tb_serial_nibble_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sclk  = 1'b0;
    logic       sdi   = 1'b0;
    logic [3:0] dout;
    logic       dout_valid, frame_done, err_frame, err_stall, busy;

    serial_nibble_rx #(.DATA_W(4), .STALL_LIMIT(8), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sclk       (sclk),
        .sdi        (sdi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .err_frame  (err_frame),
        .err_stall  (err_stall),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs every strobe seen while out of reset
    logic [3:0] words[$];
    int         valid_cyc[$];
    int n_valid = 0, n_done = 0, n_ferr = 0, n_stall = 0, n_both = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                words.push_back(dout);
                valid_cyc.push_back(cyc);
                n_valid++;
            end
            if (frame_done) n_done++;
            if (err_frame) n_ferr++;
            if (err_stall) n_stall++;
            if (dout_valid && frame_done) n_both++;
        end
    end

    int checks = 0;
    int errors = 0;
    int last_rise = 0;
    logic fbits[$];

    int idx, v0, d0, e0, s0, b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int half);
        sdi  = b;
        sclk = 1'b0;
        tick(half);
        sclk      = 1'b1;
        last_rise = cyc;
        tick(half);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        sclk  = 1'b0;
        tick(3);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        tick(2);
        start = 1'b0;
        tick(8);
    endtask

    task automatic drive_frame(input int half);
        begin_frame();
        foreach (fbits[i]) send_bit(fbits[i], half);
        end_frame();
    endtask

    task automatic snap();
        idx = words.size();
        v0  = n_valid;
        d0  = n_done;
        e0  = n_ferr;
        s0  = n_stall;
        b0  = n_both;
    endtask

    // Reference: word w is bits 4w..4w+3 of the frame, first bit most significant
    function automatic logic [3:0] exp_word(input int w);
        int v;
        v = 0;
        for (int j = 0; j < 4; j++) v = v * 2 + int'(fbits[4*w+j]);
        return 4'(v);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({dout, dout_valid, frame_done, err_frame, err_stall, busy} !== 9'h0)
            $display("FAIL reset_outputs: got %h expected 000",
                     {dout, dout_valid, frame_done, err_frame, err_stall, busy});
        if ({dout, dout_valid, frame_done, err_frame, err_stall, busy} !== 9'h0) errors++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_word();
        int r;
        snap();
        begin_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
        r = last_rise;
        end_frame();
        checks++;
        if (n_valid - v0 != 1) begin
            errors++;
            $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0);
        end
        checks++;
        if (words.size() <= idx || words[idx] !== 4'hB) begin
            errors++;
            $display("FAIL single_word: got %h expected b", (words.size() > idx) ? words[idx] : 4'hx);
        end
        checks++;
        if (valid_cyc.size() <= idx || valid_cyc[idx] - r != 4) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 4",
                     (valid_cyc.size() > idx) ? valid_cyc[idx] - r : -1);
        end
        checks++;
        if (n_done - d0 != 1 || n_ferr != e0 || n_stall != s0) begin
            errors++;
            $display("FAIL single_end: done %0d ferr %0d stall %0d expected 1 0 0",
                     n_done - d0, n_ferr - e0, n_stall - s0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        fbits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        snap();
        drive_frame(2);
        checks++;
        if (n_valid - v0 != 2) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0);
        end
        checks++;
        if (words.size() < idx + 2 || words[idx] !== 4'h3 || words[idx+1] !== 4'hC) begin
            errors++;
            $display("FAIL b2b_words: got %0d words expected 3 then c", words.size() - idx);
        end
        checks++;
        if (n_done - d0 != 1 || n_ferr != e0) begin
            errors++;
            $display("FAIL b2b_done: done %0d ferr %0d expected 1 0", n_done - d0, n_ferr - e0);
        end
    endtask

    task automatic test_partial();
        logic [3:0] prev;
        prev  = dout;
        fbits = '{1'b1, 1'b1};
        snap();
        drive_frame(2);
        checks++;
        if (n_ferr - e0 != 1 || n_done != d0) begin
            errors++;
            $display("FAIL partial_err: ferr %0d done %0d expected 1 0", n_ferr - e0, n_done - d0);
        end
        checks++;
        if (n_valid != v0 || dout !== prev) begin
            errors++;
            $display("FAIL partial_hold: valid %0d dout %h expected 0 %h", n_valid - v0, dout, prev);
        end
    endtask

    task automatic test_stall();
        snap();
        begin_frame();
        send_bit(1'b1, 2);
        tick(16);
        checks++;
        if (n_stall - s0 != 1) begin
            errors++;
            $display("FAIL stall_strobe: got %0d expected 1", n_stall - s0);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
        sclk = 1'b0;
        tick(6);
        checks++;
        if (n_valid != v0 || n_stall - s0 != 1) begin
            errors++;
            $display("FAIL stall_ignore: valid %0d stall %0d expected 0 1", n_valid - v0, n_stall - s0);
        end
        start = 1'b0;
        tick(8);
        checks++;
        if (busy !== 1'b0 || n_done != d0 || n_ferr != e0) begin
            errors++;
            $display("FAIL stall_exit: busy %b done %0d ferr %0d expected 0 0 0",
                     busy, n_done - d0, n_ferr - e0);
        end
    endtask

    task automatic test_simultaneous();
        snap();
        begin_frame();
        send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
        sdi  = 1'b0;
        sclk = 1'b0;
        tick(2);
        sclk  = 1'b1;
        start = 1'b0;
        tick(10);
        sclk = 1'b0;
        tick(2);
        checks++;
        if (n_both - b0 != 1 || n_valid - v0 != 1 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL simul_same_cycle: both %0d valid %0d done %0d expected 1 1 1",
                     n_both - b0, n_valid - v0, n_done - d0);
        end
        checks++;
        if (words.size() <= idx || words[idx] !== 4'h6 || n_ferr != e0) begin
            errors++;
            $display("FAIL simul_word: got %h ferr %0d expected 6 0",
                     (words.size() > idx) ? words[idx] : 4'hx, n_ferr - e0);
        end
    endtask

    task automatic test_async_reset();
        begin_frame();
        send_bit(1'b1, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, frame_done, err_frame, err_stall, busy} !== 9'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 000",
                     {dout, dout_valid, frame_done, err_frame, err_stall, busy});
        end
        start = 1'b0;
        sclk  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        fbits = '{1'b0, 1'b1, 1'b0, 1'b1};
        snap();
        drive_frame(2);
        checks++;
        if (n_valid - v0 != 1 || words.size() <= idx || words[idx] !== 4'h5 || dout !== 4'h5) begin
            errors++;
            $display("FAIL async_recover: valid %0d dout %h expected 1 5", n_valid - v0, dout);
        end
    endtask

    task automatic test_random_frames();
        int n, half;
        for (int f = 0; f < 20; f++) begin
            n    = int'($urandom_range(0, 12));
            half = int'($urandom_range(2, 3));
            fbits.delete();
            for (int i = 0; i < n; i++) fbits.push_back(1'($urandom_range(0, 1)));
            snap();
            drive_frame(half);
            checks++;
            if (n_valid - v0 != n / 4) begin
                errors++;
                $display("FAIL rand_valid_count[%0d]: got %0d expected %0d", f, n_valid - v0, n / 4);
            end
            for (int w = 0; w < n / 4; w++) begin
                checks++;
                if (words.size() <= idx + w || words[idx+w] !== exp_word(w)) begin
                    errors++;
                    $display("FAIL rand_word[%0d.%0d]: got %h expected %h", f, w,
                             (words.size() > idx + w) ? words[idx+w] : 4'hx, exp_word(w));
                end
            end
            checks++;
            if (n_done - d0 != ((n % 4 == 0) ? 1 : 0) || n_ferr - e0 != ((n % 4 != 0) ? 1 : 0)
                || n_stall != s0) begin
                errors++;
                $display("FAIL rand_end[%0d]: done %0d ferr %0d stall %0d for %0d bits",
                         f, n_done - d0, n_ferr - e0, n_stall - s0, n);
            end
        end
    endtask

    task automatic test_random_stall();
        int k;
        for (int f = 0; f < 6; f++) begin
            k = int'($urandom_range(0, 6));
            fbits.delete();
            for (int i = 0; i < k; i++) fbits.push_back(1'($urandom_range(0, 1)));
            snap();
            begin_frame();
            foreach (fbits[i]) send_bit(fbits[i], 2);
            tick(16);
            checks++;
            if (n_stall - s0 != 1 || busy !== 1'b1 || n_valid - v0 != k / 4) begin
                errors++;
                $display("FAIL rstall_err[%0d]: stall %0d busy %b valid %0d expected 1 1 %0d",
                         f, n_stall - s0, busy, n_valid - v0, k / 4);
            end
            if (k >= 4) begin
                checks++;
                if (words.size() <= idx || words[idx] !== exp_word(0)) begin
                    errors++;
                    $display("FAIL rstall_word[%0d]: got %h expected %h", f,
                             (words.size() > idx) ? words[idx] : 4'hx, exp_word(0));
                end
            end
            sclk  = 1'b0;
            start = 1'b0;
            tick(8);
            checks++;
            if (busy !== 1'b0 || n_done != d0 || n_ferr != e0) begin
                errors++;
                $display("FAIL rstall_exit[%0d]: busy %b done %0d ferr %0d expected 0 0 0",
                         f, busy, n_done - d0, n_ferr - e0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial();
        test_stall();
        test_simultaneous();
        test_async_reset();
        test_random_frames();
        test_random_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
